// File: rtl/seg_scan_decoder.sv
// Recovers the four digits shown on a multiplexed 7-segment display by sampling cathodes and anodes.
// Optional decimal-point capture is compiled in with SEG_SCAN_DP_EN.
module seg_scan_decoder #(
   parameter int unsigned SETTLE_N = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_en,
   input  logic [6:0] segments,
   input  logic [3:0] anode_active,
`ifdef SEG_SCAN_DP_EN
   input  logic       dp,
   output logic [3:0] dp_out,
`endif
   output logic [3:0] digit3,
   output logic [3:0] digit2,
   output logic [3:0] digit1,
   output logic [3:0] digit0,
   output logic       frame_valid,
   output logic       err_seg,
   output logic       err_anode
);

   localparam logic [3:0] SETTLE_TGT = 4'(SETTLE_N);

   typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;

   state_t          state_q, state_d;
   logic [3:0]      anode_q, anode_d;
   logic [6:0]      seg_q, seg_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      mask_q, mask_d;
   logic [3:0][3:0] shadow_q, shadow_d;
   logic [3:0][3:0] digits_q, digits_d;
   logic            frame_valid_q, frame_valid_d;
   logic            err_seg_q, err_seg_d;
   logic            err_anode_q, err_anode_d;
`ifdef SEG_SCAN_DP_EN
   logic            dp_q, dp_d;
   logic [3:0]      shadow_dp_q, shadow_dp_d;
   logic [3:0]      dp_out_q, dp_out_d;
`endif

   logic [3:0] anode_low;
   logic       anode_one;
   logic       anode_multi;
   logic       same_sample;
   logic       start;
   logic       capture;
   logic [3:0] cnt_next;
   logic [3:0] dec_val;

   function automatic logic [3:0] seg_decode(input logic [6:0] s);
      case (s)
         7'b1000000: return 4'd0;
         7'b1111001: return 4'd1;
         7'b0100100: return 4'd2;
         7'b0110000: return 4'd3;
         7'b0011001: return 4'd4;
         7'b0010010: return 4'd5;
         7'b0000010: return 4'd6;
         7'b1111000: return 4'd7;
         7'b0000000: return 4'd8;
         7'b0010000: return 4'd9;
         default:    return 4'hF;
      endcase
   endfunction

   always_comb begin
      state_d       = state_q;
      anode_d       = anode_q;
      seg_d         = seg_q;
      cnt_d         = cnt_q;
      mask_d        = mask_q;
      shadow_d      = shadow_q;
      digits_d      = digits_q;
      frame_valid_d = 1'b0;
      err_seg_d     = err_seg_q;
      err_anode_d   = err_anode_q;
      start         = 1'b0;
      capture       = 1'b0;
      cnt_next      = cnt_q + 4'd1;
      dec_val       = seg_decode(segments);
      anode_low     = ~anode_active;
      anode_multi   = (anode_low & (anode_low - 4'd1)) != 4'd0;
      anode_one     = (anode_low != 4'd0) && !anode_multi;
      same_sample   = (anode_active == anode_q) && (segments == seg_q);
`ifdef SEG_SCAN_DP_EN
      dp_d          = dp_q;
      shadow_dp_d   = shadow_dp_q;
      dp_out_d      = dp_out_q;
      same_sample   = same_sample && (dp == dp_q);
`endif

      // A full mask publishes the shadow one edge later; a capture this cycle opens the next frame.
      if (mask_q == 4'hF) begin
         digits_d      = shadow_q;
         frame_valid_d = 1'b1;
         mask_d        = 4'd0;
`ifdef SEG_SCAN_DP_EN
         dp_out_d      = shadow_dp_q;
`endif
      end

      if (sample_en) begin
         if (anode_multi) begin
            err_anode_d = 1'b1;
            state_d     = S_WAIT;
            cnt_d       = 4'd0;
         end else if (!anode_one) begin
            state_d = S_WAIT;
            cnt_d   = 4'd0;
         end else begin
            unique case (state_q)
               S_WAIT:   start = 1'b1;
               S_SETTLE: begin
                  if (same_sample) begin
                     cnt_d = cnt_next;
                     if (cnt_next == SETTLE_TGT) capture = 1'b1;
                  end else begin
                     start = 1'b1;
                  end
               end
               S_HOLD:   if (anode_active != anode_q) start = 1'b1;
               default:  state_d = S_WAIT;
            endcase
         end
      end

      if (start) begin
         anode_d = anode_active;
         seg_d   = segments;
         cnt_d   = 4'd1;
         state_d = S_SETTLE;
`ifdef SEG_SCAN_DP_EN
         dp_d    = dp;
`endif
         if (SETTLE_N == 1) capture = 1'b1;
      end

      if (capture) begin
         state_d = S_HOLD;
         mask_d  = mask_d | anode_low;
         if (dec_val == 4'hF) err_seg_d = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (anode_low[i]) begin
               shadow_d[i] = dec_val;
`ifdef SEG_SCAN_DP_EN
               shadow_dp_d[i] = ~dp;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_WAIT;
         anode_q       <= 4'hF;
         seg_q         <= 7'd0;
         cnt_q         <= 4'd0;
         mask_q        <= 4'd0;
         shadow_q      <= '0;
         digits_q      <= '0;
         frame_valid_q <= 1'b0;
         err_seg_q     <= 1'b0;
         err_anode_q   <= 1'b0;
`ifdef SEG_SCAN_DP_EN
         dp_q          <= 1'b1;
         shadow_dp_q   <= 4'd0;
         dp_out_q      <= 4'd0;
`endif
      end else begin
         state_q       <= state_d;
         anode_q       <= anode_d;
         seg_q         <= seg_d;
         cnt_q         <= cnt_d;
         mask_q        <= mask_d;
         shadow_q      <= shadow_d;
         digits_q      <= digits_d;
         frame_valid_q <= frame_valid_d;
         err_seg_q     <= err_seg_d;
         err_anode_q   <= err_anode_d;
`ifdef SEG_SCAN_DP_EN
         dp_q          <= dp_d;
         shadow_dp_q   <= shadow_dp_d;
         dp_out_q      <= dp_out_d;
`endif
      end
   end

   assign digit3      = digits_q[3];
   assign digit2      = digits_q[2];
   assign digit1      = digits_q[1];
   assign digit0      = digits_q[0];
   assign frame_valid = frame_valid_q;
   assign err_seg     = err_seg_q;
   assign err_anode   = err_anode_q;
`ifdef SEG_SCAN_DP_EN
   assign dp_out      = dp_out_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: a run-length model of the scanned display is checked every cycle,
// and directed scenes pin the model with literal expectations.
module tb_seg_scan_decoder;

   localparam int SETTLE_N = 4;
   localparam logic [6:0] SEG_TBL [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                           7'b0000000, 7'b0010000};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_en = 1'b0;
   logic [6:0] segments = 7'h7F;
   logic [3:0] anode_active = 4'hF;
   logic       dp = 1'b1;
   logic [3:0] digit3, digit2, digit1, digit0;
   logic       frame_valid, err_seg, err_anode;
`ifdef SEG_SCAN_DP_EN
   logic [3:0] dp_out;
`endif

   int total = 0;
   int bad = 0;
   int fv_seen = 0;
   bit check_on = 1'b0;

   seg_scan_decoder #(.SETTLE_N(SETTLE_N)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_en    (sample_en),
      .segments     (segments),
      .anode_active (anode_active),
`ifdef SEG_SCAN_DP_EN
      .dp           (dp),
      .dp_out       (dp_out),
`endif
      .digit3       (digit3),
      .digit2       (digit2),
      .digit1       (digit1),
      .digit0       (digit0),
      .frame_valid  (frame_valid),
      .err_seg      (err_seg),
      .err_anode    (err_anode)
   );

   always #5 clk = ~clk;

   // Model state: the current run of identical samples on one anode and the frame being assembled.
   bit         m_live, m_done;
   int         m_len;
   logic [3:0] m_anode;
   logic [6:0] m_seg;
   logic       m_dp;
   logic [3:0] m_shadow [4];
   logic [3:0] m_sdp;
   logic [3:0] m_mask;
   logic [3:0] exp_digit [4];
   logic [3:0] exp_dp_out;
   logic       exp_fv, exp_err_seg, exp_err_anode;

   function automatic logic [3:0] decodeSeg(input logic [6:0] s);
      for (int i = 0; i < 10; i++) if (SEG_TBL[i] == s) return 4'(i);
      return 4'hF;
   endfunction

   function automatic int lowCount(input logic [3:0] a);
      int n = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) n++;
      return n;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_live = 0; m_done = 0; m_len = 0; m_mask = 0; m_sdp = 0;
         exp_fv = 0; exp_err_seg = 0; exp_err_anode = 0; exp_dp_out = 0;
         for (int i = 0; i < 4; i++) begin m_shadow[i] = 0; exp_digit[i] = 0; end
      end else begin
         exp_fv = 0;
         if (m_mask == 4'hF) begin
            for (int i = 0; i < 4; i++) exp_digit[i] = m_shadow[i];
            exp_dp_out = m_sdp;
            exp_fv = 1;
            m_mask = 0;
         end
         if (sample_en) begin
            if (lowCount(anode_active) >= 2) begin
               exp_err_anode = 1;
               m_live = 0;
            end else if (lowCount(anode_active) == 0) begin
               m_live = 0;
            end else if (!(m_live && m_done && anode_active == m_anode)) begin
               if (m_live && !m_done && anode_active == m_anode && segments == m_seg && dp == m_dp)
                  m_len++;
               else begin
                  m_live = 1; m_done = 0; m_len = 1;
                  m_anode = anode_active; m_seg = segments; m_dp = dp;
               end
               if (m_len == SETTLE_N) begin
                  m_done = 1;
                  for (int i = 0; i < 4; i++) begin
                     if (!anode_active[i]) begin
                        m_shadow[i] = decodeSeg(segments);
                        m_sdp[i] = !dp;
                        m_mask[i] = 1'b1;
                     end
                  end
                  if (decodeSeg(segments) == 4'hF) exp_err_seg = 1;
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (frame_valid === 1'b1) fv_seen++;
      if (check_on) begin
         checkOutput("digit3", 32'(digit3), 32'(exp_digit[3]));
         checkOutput("digit2", 32'(digit2), 32'(exp_digit[2]));
         checkOutput("digit1", 32'(digit1), 32'(exp_digit[1]));
         checkOutput("digit0", 32'(digit0), 32'(exp_digit[0]));
         checkOutput("frame_valid", 32'(frame_valid), 32'(exp_fv));
         checkOutput("err_seg", 32'(err_seg), 32'(exp_err_seg));
         checkOutput("err_anode", 32'(err_anode), 32'(exp_err_anode));
`ifdef SEG_SCAN_DP_EN
         checkOutput("dp_out", 32'(dp_out), 32'(exp_dp_out));
`endif
      end
   end

   task automatic applyStimulus(input logic [3:0] an, input logic [6:0] sg, input logic d, input int n);
      repeat (n) begin
         @(negedge clk);
         anode_active = an; segments = sg; dp = d; sample_en = 1'b1;
         @(negedge clk);
         sample_en = 1'b0;
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; sample_en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      doReset();
      check_on = 1'b1;
      checkOutput("reset digit3", 32'(digit3), 32'h0);
      checkOutput("reset digit0", 32'(digit0), 32'h0);
      checkOutput("reset frame_valid", 32'(frame_valid), 32'h0);
      checkOutput("reset err_seg", 32'(err_seg), 32'h0);

      // Basic frame 1,2,3,4 with a decimal point on the second digit only.
      applyStimulus(4'b0111, SEG_TBL[1], 1'b1, 6);
      applyStimulus(4'b1011, SEG_TBL[2], 1'b0, 6);
      applyStimulus(4'b1101, SEG_TBL[3], 1'b1, 6);
      applyStimulus(4'b1110, SEG_TBL[4], 1'b1, 6);
      applyStimulus(4'b1111, 7'h7F, 1'b1, 1);
      idle(3);
      checkOutput("frame1 digit3", 32'(digit3), 32'd1);
      checkOutput("frame1 digit2", 32'(digit2), 32'd2);
      checkOutput("frame1 digit1", 32'(digit1), 32'd3);
      checkOutput("frame1 digit0", 32'(digit0), 32'd4);
      checkOutput("frame1 pulses", 32'(fv_seen), 32'd1);
      checkOutput("blank no err_anode", 32'(err_anode), 32'd0);
`ifdef SEG_SCAN_DP_EN
      checkOutput("frame1 dp_out", 32'(dp_out), 32'b0100);
`endif

      // Too-short dwell on the leftmost digit captures nothing, so no frame completes.
      applyStimulus(4'b0111, SEG_TBL[5], 1'b1, 3);
      applyStimulus(4'b1011, SEG_TBL[6], 1'b1, 6);
      applyStimulus(4'b1101, SEG_TBL[7], 1'b1, 6);
      applyStimulus(4'b1110, SEG_TBL[8], 1'b1, 6);
      idle(3);
      checkOutput("short dwell pulses", 32'(fv_seen), 32'd1);
      checkOutput("short dwell digit3", 32'(digit3), 32'd1);
      applyStimulus(4'b0111, SEG_TBL[9], 1'b1, 4);
      idle(3);
      checkOutput("frame2 pulses", 32'(fv_seen), 32'd2);
      checkOutput("frame2 digit3", 32'(digit3), 32'd9);
      checkOutput("frame2 digit0", 32'(digit0), 32'd8);

      // Undecodable pattern on digit0, plus a segment change that restarts settling.
      applyStimulus(4'b1110, 7'h7F, 1'b1, 4);
      applyStimulus(4'b0111, SEG_TBL[0], 1'b1, 4);
      applyStimulus(4'b1011, SEG_TBL[1], 1'b1, 4);
      applyStimulus(4'b1101, SEG_TBL[3], 1'b1, 2);
      applyStimulus(4'b1101, SEG_TBL[2], 1'b1, 4);
      idle(3);
      checkOutput("bad seg err_seg", 32'(err_seg), 32'd1);
      checkOutput("bad seg digit0", 32'(digit0), 32'hF);
      checkOutput("restart digit1", 32'(digit1), 32'd2);

      // Two anodes low at once flags the error on that very sample.
      applyStimulus(4'b0011, SEG_TBL[8], 1'b1, 1);
      checkOutput("multi anode err", 32'(err_anode), 32'd1);

      // Recapture overwrites; a segment change while holding the same anode is ignored.
      applyStimulus(4'b0111, SEG_TBL[1], 1'b1, 4);
      applyStimulus(4'b0111, SEG_TBL[7], 1'b1, 4);
      applyStimulus(4'b1011, SEG_TBL[2], 1'b1, 4);
      applyStimulus(4'b0111, SEG_TBL[5], 1'b1, 4);
      applyStimulus(4'b1101, SEG_TBL[3], 1'b1, 4);
      applyStimulus(4'b1110, SEG_TBL[4], 1'b1, 4);
      idle(3);
      checkOutput("overwrite digit3", 32'(digit3), 32'd5);
      checkOutput("overwrite pulses", 32'(fv_seen), 32'd4);

      // Reset mid-frame discards the partial frame and clears sticky errors.
      applyStimulus(4'b0111, SEG_TBL[6], 1'b1, 4);
      applyStimulus(4'b1011, SEG_TBL[6], 1'b1, 4);
      applyStimulus(4'b1101, SEG_TBL[6], 1'b1, 4);
      doReset();
      checkOutput("post reset err_seg", 32'(err_seg), 32'd0);
      checkOutput("post reset err_anode", 32'(err_anode), 32'd0);
      applyStimulus(4'b1110, SEG_TBL[6], 1'b1, 6);
      idle(4);
      checkOutput("partial frame pulses", 32'(fv_seen), 32'd4);
      checkOutput("partial frame digit3", 32'(digit3), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have parameter SETTLE_N, default 4, meaning consecutive stable samples required before a digit is captured (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port sample_en, input, 1 bit, single-cycle sample strobe; state advances only when high.
REQ-005 The block SHALL have port segments, input, 7 bits, active-low cathodes, bit0=a through bit6=g.
REQ-006 The block SHALL have port anode_active, input, 4 bits, active-low digit selects; bit3 is the leftmost digit.
REQ-007 The block SHALL have port digit3..digit0, output, 4 bits each, last complete frame, one value per anode position.
REQ-008 The block SHALL have port frame_valid, output, 1 bit, one-clock pulse when the digit outputs update.
REQ-009 The block SHALL have port err_seg and err_anode, output, 1 bit each, sticky error flags.

Function
REQ-010 The decode table SHALL be (segments to value): 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9; any other pattern SHALL decode to 4'hF.
REQ-011 The FSM SHALL have states WAIT (no valid anode), SETTLE (counting stable samples) and HOLD (digit captured, waiting for the anode to change).
REQ-012 A valid anode SHALL be exactly one bit of anode_active low; all-high SHALL be treated as blanking and cause no error.
REQ-013 In WAIT on a sample with a valid anode, the FSM SHALL latch anode and segments, set the stable count to 1, and enter SETTLE; if SETTLE_N=1, it SHALL capture immediately and enter HOLD.
REQ-014 In SETTLE, a sample with an identical anode and segments SHALL increment the count; when the count reaches SETTLE_N, the FSM SHALL capture the decoded value into the shadow slot for that anode, set that mask bit, and enter HOLD.
REQ-015 In SETTLE, a sample with a changed anode or segments SHALL restart the count at 1 with the new values, or return to WAIT if the anode is not valid.
REQ-016 In HOLD, a sample with a different valid anode SHALL behave as the WAIT entry of REQ-013; an invalid anode SHALL go to WAIT; the same anode SHALL stay in HOLD.
REQ-017 A capture of a 4'hF value SHALL set err_seg, and the 4'hF value SHALL still be stored.
REQ-018 Any sample with two or more anodes low SHALL set err_anode, return to WAIT, and capture nothing.
REQ-019 Recapturing an already-masked position before the frame completes SHALL overwrite its shadow slot.
REQ-020 On the cycle the mask becomes 4'b1111, the block SHALL copy the shadow to digit3..0 on the next edge, pulse frame_valid high for exactly one clk, and clear the mask; a capture in that same cycle SHALL start the new frame.
REQ-021 Error flags SHALL clear only on rst.
REQ-022 With sample_en low, all state SHALL hold, and frame_valid SHALL be low except for the single pulse of REQ-020.

Reset
REQ-023 On rst=1 at a clk edge: state=WAIT, count=0, mask=0, shadow=0, digit3..0=0, frame_valid=0, err_seg=0, err_anode=0.
REQ-024 Reset SHALL take priority over sample_en, and a reset mid-frame SHALL discard the partial frame.

Configuration
REQ-025 With macro SEG_SCAN_DP_EN defined, the block SHALL add input dp (1 bit, active-low) and output dp_out (4 bits); dp SHALL be sampled and compared alongside segments for stability; its captured value SHALL be inverted and copied to dp_out[position] with the frame.
REQ-026 Without SEG_SCAN_DP_EN, the dp and dp_out ports and their logic SHALL NOT exist.

Verification
REQ-027 With SETTLE_N=4, driving anodes 0111,1011,1101,1110 with patterns for 1,2,3,4, each held for 6 samples, SHALL give digit3..0=1,2,3,4 and exactly one frame_valid pulse after the 4th sample of the last digit.
REQ-028 Holding anode 0111 for only 3 samples, then changing it, SHALL capture nothing and leave mask bit3 at 0.
REQ-029 Segments 1111111 held stable on anode 1110 for 4 samples SHALL give err_seg=1, and digit0=F after the frame.
REQ-030 Anode 0011 SHALL give err_anode=1 the same sample, with no capture and the state in WAIT.
REQ-031 rst asserted after 3 of 4 digits are captured, followed by 1 digit, SHALL produce no frame_valid; a full 4-digit frame is required.
REQ-032 With SEG_SCAN_DP_EN defined, dp=0 on anode 1011 only SHALL give dp_out=4'b0100 at frame_valid.
